// File: rtl/bus_sequencer.sv
// Bus sequencer: arbitrates CPU and NCH DMA channels onto one external bus
// with ADDR/WAIT/DATA phases, round-robin DMA grant and optional CPU fairness.
// Ports: PHI0 clock, n_RES async active-low reset; cpu_* and dma_* requests
// (dma packed, channel 0 in LSBs); wait_cfg wait states; ext_rdy/ext_rdata
// from the bus; ab/rw/db_out/db_oe bus drive; rdata last read; cpu_ack and
// dma_done completion pulses; n_ready CPU stall; busy when not idle.
// Macro BUS_SEQ_FAIR_EN: after a DMA access completes with cpu_req high, the
// next grant goes to the CPU.
module bus_sequencer #(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int NCH = 2,
  parameter int WSW = 3
) (
  input  logic              PHI0,
  input  logic              n_RES,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_wdata,
  input  logic [NCH-1:0]    dma_req,
  input  logic [NCH-1:0]    dma_rw,
  input  logic [NCH*AW-1:0] dma_addr,
  input  logic [NCH*DW-1:0] dma_wdata,
  input  logic [WSW-1:0]    wait_cfg,
  input  logic              ext_rdy,
  input  logic [DW-1:0]     ext_rdata,
  output logic [AW-1:0]     ab,
  output logic              rw,
  output logic [DW-1:0]     db_out,
  output logic              db_oe,
  output logic [DW-1:0]     rdata,
  output logic              cpu_ack,
  output logic [NCH-1:0]    dma_done,
  output logic              n_ready,
  output logic              busy
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    DATA
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            own_cpu;
  logic [CW-1:0]   own_ch;
  logic [CW-1:0]   rr_ptr;
  logic [DW-1:0]   wd_q;
  logic [WSW-1:0]  cnt;

  logic            take;
  logic            fin;
  logic            grant;
  logic            gnt_cpu;
  logic [NCH-1:0]  rot;
  logic [CW-1:0]   sel;
  logic [CW:0]     sum;
  logic [CW-1:0]   gnt_ch;
  logic [CW-1:0]   ptr_nx;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_rw;
  logic [NCH-1:0]  done_vec;

  // Rotate requests so the search starts at rr_ptr, then map back.
  always_comb begin
    rot = NCH'({dma_req, dma_req} >> rr_ptr);
    sel = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) sel = CW'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, sel};
    if (sum >= (CW + 1)'(NCH)) sum = sum - (CW + 1)'(NCH);
    gnt_ch = sum[CW-1:0];
    ptr_nx = (gnt_ch == CW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
  end

  always_comb begin
    d_addr   = '0;
    d_wdata  = '0;
    d_rw     = 1'b1;
    done_vec = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_ch == CW'(i)) begin
        d_addr  = dma_addr[i*AW +: AW];
        d_wdata = dma_wdata[i*DW +: DW];
        d_rw    = dma_rw[i];
      end
      done_vec[i] = fin && !own_cpu && (own_ch == CW'(i));
    end
  end

  always_comb begin
    state_nx = state;
    take     = cpu_req || (|dma_req);
    fin      = (state == DATA) && ext_rdy;
    grant    = take && ((state == IDLE) || fin);
`ifdef BUS_SEQ_FAIR_EN
    gnt_cpu  = !(|dma_req) || (fin && !own_cpu && cpu_req);
`else
    gnt_cpu  = !(|dma_req);
`endif
    unique case (state)
      IDLE: if (take) state_nx = ADDR;
      ADDR: state_nx = (cnt != '0) ? WAIT : DATA;
      WAIT: if (cnt == WSW'(1)) state_nx = DATA;
      DATA: if (ext_rdy) state_nx = take ? ADDR : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      own_cpu  <= 1'b0;
      own_ch   <= '0;
      ab       <= '0;
      rw       <= 1'b1;
      wd_q     <= '0;
      cnt      <= '0;
      rdata    <= '0;
      cpu_ack  <= 1'b0;
      dma_done <= '0;
    end else begin
      state    <= state_nx;
      cpu_ack  <= fin && own_cpu;
      dma_done <= done_vec;
      if (fin && rw) rdata <= ext_rdata;
      if (state == WAIT) cnt <= cnt - 1'b1;
      if (grant) begin
        own_cpu <= gnt_cpu;
        cnt     <= wait_cfg;
        if (gnt_cpu) begin
          ab   <= cpu_addr;
          rw   <= cpu_rw;
          wd_q <= cpu_wdata;
        end else begin
          ab     <= d_addr;
          rw     <= d_rw;
          wd_q   <= d_wdata;
          own_ch <= gnt_ch;
          rr_ptr <= ptr_nx;
        end
      end
    end
  end

  assign busy    = (state != IDLE);
  assign db_oe   = busy && !rw;
  assign db_out  = db_oe ? wd_q : '0;
  assign n_ready = ~(cpu_req & ~cpu_ack);

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: transaction-level reference model and scoreboard,
// directed scenarios followed by randomized traffic.
module tb_bus_sequencer;

  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int NCH = 2;
  localparam int WSW = 3;

  logic              PHI0 = 1'b0;
  logic              n_RES = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_rw = 1'b1;
  logic [AW-1:0]     cpu_addr = '0;
  logic [DW-1:0]     cpu_wdata = '0;
  logic [NCH-1:0]    dma_req = '0;
  logic [NCH-1:0]    dma_rw = '1;
  logic [NCH*AW-1:0] dma_addr = '0;
  logic [NCH*DW-1:0] dma_wdata = '0;
  logic [WSW-1:0]    wait_cfg = '0;
  logic              ext_rdy = 1'b1;
  logic [DW-1:0]     ext_rdata = '0;
  logic [AW-1:0]     ab;
  logic              rw;
  logic [DW-1:0]     db_out;
  logic              db_oe;
  logic [DW-1:0]     rdata;
  logic              cpu_ack;
  logic [NCH-1:0]    dma_done;
  logic              n_ready;
  logic              busy;

  bus_sequencer #(.AW(AW), .DW(DW), .NCH(NCH), .WSW(WSW)) dut (
    .PHI0(PHI0), .n_RES(n_RES),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_rw(dma_rw),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .wait_cfg(wait_cfg), .ext_rdy(ext_rdy), .ext_rdata(ext_rdata),
    .ab(ab), .rw(rw), .db_out(db_out), .db_oe(db_oe),
    .rdata(rdata), .cpu_ack(cpu_ack), .dma_done(dma_done),
    .n_ready(n_ready), .busy(busy)
  );

  always #5 PHI0 = ~PHI0;

  typedef struct {
    int          own;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   log_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   oe_cnt = 0;
  int   bz_low = 0;

  // Reference model: owner NCH stands for the CPU.
  bit            m_act;
  int            m_n, m_w, m_own, m_ptr;
  logic          m_rw;
  logic [AW-1:0] m_ab;
  logic [DW-1:0] m_wd, m_rd;
  logic          m_ack;
  logic [NCH-1:0] m_done;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int arb(input bit fair_cpu);
    if (fair_cpu) return NCH;
    if (dma_req != '0) begin
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (m_ptr + i) % NCH;
        if (dma_req[c]) return c;
      end
    end
    if (cpu_req) return NCH;
    return -1;
  endfunction

  always @(posedge PHI0 or negedge n_RES) begin
    if (!n_RES) begin
      m_act = 0; m_n = 0; m_w = 0; m_own = 0; m_ptr = 0;
      m_rw = 1'b1; m_ab = '0; m_wd = '0; m_rd = '0;
      m_ack = 1'b0; m_done = '0;
      sb.delete();
    end else begin
      bit fin_dma;
      int g;
      fin_dma = 0;
      m_ack = 1'b0;
      m_done = '0;
      if (m_act) begin
        m_n++;
        // access length is 2 + wait states, then stretched by ext_rdy
        if (m_n >= 2 + m_w && ext_rdy) begin
          m_act = 0;
          if (m_rw) m_rd = ext_rdata;
          if (m_own == NCH) m_ack = 1'b1;
          else begin
            m_done[m_own] = 1'b1;
            fin_dma = 1;
          end
          sb.push_back('{m_own, m_rd});
        end
      end
      if (!m_act) begin
`ifdef BUS_SEQ_FAIR_EN
        g = arb(fin_dma && cpu_req);
`else
        g = arb(1'b0);
`endif
        if (g >= 0) begin
          m_act = 1; m_n = 0; m_w = int'(wait_cfg); m_own = g;
          if (g == NCH) begin
            m_ab = cpu_addr; m_rw = cpu_rw; m_wd = cpu_wdata;
          end else begin
            m_ab = dma_addr[g*AW +: AW];
            m_rw = dma_rw[g];
            m_wd = dma_wdata[g*DW +: DW];
            m_ptr = (g + 1) % NCH;
          end
        end
      end
    end
  end

  // Monitor: per-cycle bus checks plus scoreboard pop on completion pulses.
  always @(negedge PHI0) begin
    if (n_RES) begin
      int   who;
      exp_t e;
      chk("busy", 32'(busy), 32'(m_act));
      chk("cpu_ack", 32'(cpu_ack), 32'(m_ack));
      chk("dma_done", 32'(dma_done), 32'(m_done));
      chk("ab", 32'(ab), 32'(m_ab));
      chk("rw", 32'(rw), 32'(m_rw));
      chk("db_oe", 32'(db_oe), 32'(m_act && !m_rw));
      chk("db_out", 32'(db_out), (m_act && !m_rw) ? 32'(m_wd) : 32'd0);
      chk("rdata", 32'(rdata), 32'(m_rd));
      chk("n_ready", 32'(n_ready), 32'(!(cpu_req && !m_ack)));
      if (db_oe) oe_cnt++;
      if (!busy) bz_low++;
      if (cpu_ack || dma_done != '0) begin
        who = NCH;
        for (int i = 0; i < NCH; i++) if (dma_done[i]) who = i;
        log_q.push_back(who);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_empty: pulse from %0d with nothing expected", who);
        end else begin
          e = sb.pop_front();
          chk("owner", 32'(who), 32'(e.own));
          chk("rdata_done", 32'(rdata), 32'(e.rd));
        end
      end
    end
  end

  task automatic step();
    @(posedge PHI0);
    #2;
  endtask

  task automatic wait_log(input int n, input int lim);
    int k;
    k = 0;
    while (log_q.size() < n && k < lim) begin
      @(negedge PHI0);
      k++;
    end
    chk("wait_log_timeout", 32'(log_q.size() >= n), 32'd1);
  endtask

  initial begin
    int exp3;
    #1 n_RES = 1'b0;
    #2;
    chk("rst_ab", 32'(ab), 32'd0);
    chk("rst_rw", 32'(rw), 32'd1);
    chk("rst_db_oe", 32'(db_oe), 32'd0);
    chk("rst_db_out", 32'(db_out), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'({dma_done, cpu_ack}), 32'd0);
    step();
    n_RES = 1'b1;
    step();

    // CPU read, no wait states
    cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h1234;
    ext_rdata = 8'hA5; ext_rdy = 1'b1; wait_cfg = '0;
    step();
    cpu_req = 1'b0;
    repeat (4) step();
    chk("cpu_rd_data", 32'(rdata), 32'h0000_00A5);
    chk("cpu_rd_cnt", 32'(log_q.size()), 32'd1);
    chk("cpu_rd_own", 32'(log_q[0]), 32'(NCH));

    // DMA ch1 write, 3 wait states, 2 stretched DATA cycles
    log_q.delete();
    oe_cnt = 0;
    ext_rdy = 1'b0;
    dma_req = 2'b10; dma_rw = 2'b00;
    dma_wdata = 16'h5A00; dma_addr = 32'hBEEF_0000; wait_cfg = 3'd3;
    step();
    dma_req = '0;
    repeat (6) step();
    ext_rdy = 1'b1;
    repeat (3) step();
    chk("dma_oe_cycles", 32'(oe_cnt), 32'd7);
    chk("dma_done_cnt", 32'(log_q.size()), 32'd1);
    chk("dma_done_own", 32'(log_q[0]), 32'd1);

    // Both channels held: round-robin, back-to-back
    log_q.delete();
    dma_req = 2'b11; dma_rw = 2'b11; wait_cfg = '0;
    step();
    bz_low = 0;
    wait_log(4, 40);
    chk("rr_busy_gap", 32'(bz_low), 32'd0);
    for (int i = 0; i < 4; i++) chk("rr_order", 32'(log_q[i]), 32'(i % 2));
    dma_req = '0;
    repeat (8) step();

    // CPU competing with channel 0
    log_q.delete();
    cpu_req = 1'b1; cpu_rw = 1'b1; dma_req = 2'b01;
    wait_log(3, 40);
`ifdef BUS_SEQ_FAIR_EN
    exp3 = NCH;
`else
    exp3 = 0;
`endif
    chk("prio_0", 32'(log_q[0]), 32'd0);
    chk("prio_1", 32'(log_q[1]), 32'(exp3));
    chk("prio_2", 32'(log_q[2]), 32'd0);
    cpu_req = 1'b0; dma_req = '0;
    repeat (8) step();

    // Reset during WAIT of a write
    dma_req = 2'b01; dma_rw = 2'b00; wait_cfg = 3'd5;
    step();
    dma_req = '0;
    step();
    n_RES = 1'b0;
    #1;
    chk("rst_mid_oe", 32'(db_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    log_q.delete();
    step();
    step();
    n_RES = 1'b1;
    step();
    chk("rst_no_pulse", 32'(log_q.size()), 32'd0);
    cpu_req = 1'b1; cpu_rw = 1'b0; cpu_wdata = 8'h3C; wait_cfg = '0;
    step();
    cpu_req = 1'b0;
    repeat (4) step();
    chk("post_rst_cnt", 32'(log_q.size()), 32'd1);
    chk("post_rst_own", 32'(log_q[0]), 32'(NCH));

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step();
      cpu_req   = ($urandom % 4) == 0;
      cpu_rw    = 1'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_wdata = DW'($urandom);
      for (int i = 0; i < NCH; i++) dma_req[i] = ($urandom % 5) == 0;
      dma_rw    = NCH'($urandom);
      dma_addr  = (NCH*AW)'($urandom);
      dma_wdata = (NCH*DW)'($urandom);
      wait_cfg  = (($urandom % 8) == 0) ? 3'd7 : WSW'($urandom_range(0, 2));
      ext_rdy   = ($urandom % 3) != 0;
      ext_rdata = DW'($urandom);
    end
    cpu_req = 1'b0; dma_req = '0; ext_rdy = 1'b1;
    repeat (30) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
